// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and widths for the register-file write arbiter.
// Optional feature macro: RF_LU_BYPASS_EN (see regfile_write_arbiter.sv).
package regfile_write_arbiter_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    // One register-file write: destination index plus data.
    typedef struct packed {
        logic [ADDR_W-1:0] wreg;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/regfile_write_arbiter_rf_wr_fifo.sv
// Small synchronous FIFO holding long-latency-unit results waiting for the
// register-file write port. DEPTH must be a power of two so the pointers
// wrap naturally. Push when full and pop when empty are ignored.
module rf_wr_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  logic   pop_i,
    input  rf_wr_t din_i,
    output rf_wr_t dout_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rf_wr_t        mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [PW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];

    // Pointer and occupancy tracking; cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and
// the long-latency unit, tracks LU destinations in a busy scoreboard and
// raises the decode stall.
// Optional feature macro: RF_LU_BYPASS_EN -- when defined, an LU result that
// finds the queue empty and the port free is written in the same cycle.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              wb_RegWrite,
    input  logic [ADDR_W-1:0] wb_WriteReg,
    input  logic [DATA_W-1:0] wb_WriteData,
    input  logic              lu_issue_valid,
    input  logic [ADDR_W-1:0] lu_issue_reg,
    input  logic              lu_done_valid,
    input  logic [ADDR_W-1:0] lu_done_reg,
    input  logic [DATA_W-1:0] lu_done_data,
    output logic              lu_done_ready,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic              rf_RegWrite,
    output logic [ADDR_W-1:0] rf_WriteReg,
    output logic [DATA_W-1:0] rf_WriteData,
    output logic              stall
);

    localparam int NREG = 2**ADDR_W;
    localparam int SW   = $clog2(STARVE_LIMIT + 1);

    rf_wr_t          q_head;
    rf_wr_t          q_din;
    logic            q_full;
    logic            q_empty;
    logic            q_push;
    logic            q_pop;
    logic            wb_grant;
    logic            bypass;
    rf_wr_t          grant;
    logic            grant_valid;
    logic [NREG-1:0] busy_q, busy_d;
    logic [SW-1:0]   starve_q, starve_d;

    assign q_din = '{wreg: lu_done_reg, data: lu_done_data};

    rf_wr_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk_i   (Clk),
        .rst_i   (reset),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .din_i   (q_din),
        .dout_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Port arbitration: WB first, then queue head, then (optionally) a bypassed LU result.
    always_comb begin
        wb_grant = wb_RegWrite && (wb_WriteReg != ZERO_REG);
        q_pop    = !wb_grant && !q_empty;
`ifdef RF_LU_BYPASS_EN
        bypass   = q_empty && !wb_grant && lu_done_valid && (lu_done_reg != ZERO_REG);
`else
        bypass   = 1'b0;
`endif
        // Results for $0 are acknowledged but dropped.
        q_push   = lu_done_valid && !q_full && (lu_done_reg != ZERO_REG) && !bypass;
        grant       = '0;
        grant_valid = 1'b0;
        if (wb_grant) begin
            grant       = '{wreg: wb_WriteReg, data: wb_WriteData};
            grant_valid = 1'b1;
        end else if (!q_empty) begin
            grant       = q_head;
            grant_valid = 1'b1;
        end else if (bypass) begin
            grant       = q_din;
            grant_valid = 1'b1;
        end
    end

    // Scoreboard and starvation next-state; a new issue wins over a same-cycle clear.
    always_comb begin
        busy_d = busy_q;
        if (q_pop)  busy_d[q_head.wreg] = 1'b0;
        if (bypass) busy_d[lu_done_reg] = 1'b0;
        if (lu_issue_valid) busy_d[lu_issue_reg] = 1'b1;
        busy_d[ZERO_REG] = 1'b0;

        starve_d = starve_q;
        if (q_empty || q_pop)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
    end

    // State registers.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            busy_q   <= '0;
            starve_q <= '0;
        end else begin
            busy_q   <= busy_d;
            starve_q <= starve_d;
        end
    end

    // Outputs are forced quiet while reset is held, independent of the WB inputs.
    always_comb begin
        rf_RegWrite   = grant_valid && !reset;
        rf_WriteReg   = reset ? '0 : grant.wreg;
        rf_WriteData  = reset ? '0 : grant.data;
        lu_done_ready = !q_full && !reset;
        stall         = !reset && (busy_q[ReadReg1] || busy_q[ReadReg2] ||
                                   (lu_issue_valid && busy_q[lu_issue_reg]) ||
                                   (starve_q == SW'(STARVE_LIMIT)));
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed
// by random traffic, checked against a queue/array reference model.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int QDEPTH = 2;
    localparam int LIMIT  = 4;
`ifdef RF_LU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              reset;
    logic              wb_RegWrite;
    logic [ADDR_W-1:0] wb_WriteReg;
    logic [DATA_W-1:0] wb_WriteData;
    logic              lu_issue_valid;
    logic [ADDR_W-1:0] lu_issue_reg;
    logic              lu_done_valid;
    logic [ADDR_W-1:0] lu_done_reg;
    logic [DATA_W-1:0] lu_done_data;
    logic              lu_done_ready;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic              rf_RegWrite;
    logic [ADDR_W-1:0] rf_WriteReg;
    logic [DATA_W-1:0] rf_WriteData;
    logic              stall;

    regfile_write_arbiter #(.QDEPTH(QDEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .Clk(Clk), .reset(reset),
        .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg), .wb_WriteData(wb_WriteData),
        .lu_issue_valid(lu_issue_valid), .lu_issue_reg(lu_issue_reg),
        .lu_done_valid(lu_done_valid), .lu_done_reg(lu_done_reg), .lu_done_data(lu_done_data),
        .lu_done_ready(lu_done_ready),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .rf_RegWrite(rf_RegWrite), .rf_WriteReg(rf_WriteReg), .rf_WriteData(rf_WriteData),
        .stall(stall)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int                stamp;
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state.
    rf_wr_t m_q[$];
    bit     m_busy[32];
    int     m_starve;

    always @(posedge Clk) cyc++;

    // Monitor: every write the DUT presents must match the oldest expectation for this cycle.
    always @(negedge Clk) begin
        exp_t e;
        if (!reset && rf_RegWrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_write_unexpected: got reg %0d data %h, required no write (cycle %0d)",
                         rf_WriteReg, rf_WriteData, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.stamp != cyc || e.r != rf_WriteReg || e.d != rf_WriteData) begin
                    errors++;
                    $display("FAIL rf_write: got reg %0d data %h at cycle %0d, required reg %0d data %h at cycle %0d",
                             rf_WriteReg, rf_WriteData, cyc, e.r, e.d, e.stamp);
                end
            end
        end else if (!reset && exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
            checks++;
            errors++;
            $display("FAIL rf_write_missing: got no write, required reg %0d data %h (cycle %0d)",
                     exp_q[0].r, exp_q[0].d, cyc);
            void'(exp_q.pop_front());
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One cycle: drive inputs, predict, check at negedge, then advance the model.
    task automatic step(input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd,
                        input logic iv, input logic [4:0] ir,
                        input logic dv, input logic [4:0] dr, input logic [31:0] dd,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit     wbg, ready, pop, byp, e_stall;
        rf_wr_t head;
        exp_t   e;
        int     pre_size;
        wb_RegWrite = wbw; wb_WriteReg = wbr; wb_WriteData = wbd;
        lu_issue_valid = iv; lu_issue_reg = ir;
        lu_done_valid = dv; lu_done_reg = dr; lu_done_data = dd;
        ReadReg1 = r1; ReadReg2 = r2;

        pre_size = m_q.size();
        wbg   = wbw && (wbr != 0);
        ready = (pre_size < QDEPTH);
        pop   = !wbg && (pre_size > 0);
        byp   = BYP && !wbg && (pre_size == 0) && dv && (dr != 0);
        e.stamp = cyc;
        if (wbg) begin
            e.r = wbr; e.d = wbd; exp_q.push_back(e);
        end else if (pop) begin
            e.r = m_q[0].wreg; e.d = m_q[0].data; exp_q.push_back(e);
        end else if (byp) begin
            e.r = dr; e.d = dd; exp_q.push_back(e);
        end
        e_stall = m_busy[r1] || m_busy[r2] || (iv && m_busy[ir]) || (m_starve == LIMIT);

        @(negedge Clk);
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        chk("lu_done_ready", {31'd0, lu_done_ready}, {31'd0, ready});

        if (pop) begin
            head = m_q.pop_front();
            m_busy[head.wreg] = 1'b0;
        end
        if (byp) m_busy[dr] = 1'b0;
        if (dv && ready && dr != 0 && !byp) m_q.push_back('{wreg: dr, data: dd});
        if (iv) m_busy[ir] = 1'b1;
        m_busy[0] = 1'b0;
        if (pre_size == 0 || pop) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;

        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] r1);
        step(0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
    endtask

    initial begin
        m_starve = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        reset = 1'b1;
        wb_RegWrite = 1'b1; wb_WriteReg = 5'd8; wb_WriteData = 32'h3;
        lu_issue_valid = 0; lu_issue_reg = 0;
        lu_done_valid = 0; lu_done_reg = 0; lu_done_data = 0;
        ReadReg1 = 0; ReadReg2 = 0;
        #2;
        chk("reset_rf_RegWrite", {31'd0, rf_RegWrite}, 32'd0);
        chk("reset_ready", {31'd0, lu_done_ready}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_rf_WriteReg", {27'd0, rf_WriteReg}, 32'd0);
        @(posedge Clk); @(posedge Clk); #1;
        reset = 1'b0;

        idle(0);
        // WB write and suppressed $0 write.
        step(1, 8, 32'h3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        // LU hazard on $9, completion, and stall release.
        step(0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
        idle(9);
        step(0, 0, 0, 0, 0, 1, 9, 32'h4, 9, 0);
        idle(9);
        idle(9);
        // WB hogging the port while two LU results wait: queue fills, starvation stall.
        step(1, 1, 32'hA1, 1, 11, 1, 11, 32'hB1, 0, 0);
        step(1, 2, 32'hA2, 1, 12, 1, 12, 32'hB2, 0, 0);
        step(1, 3, 32'hA3, 0, 0, 1, 13, 32'hB3, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 5'(4 + i), 32'hC0 + i, 0, 0, 0, 0, 0, 0, 0);
        idle(11);
        idle(12);
        idle(12);
        // Reissue of $10 in the cycle its older result pops keeps it busy.
        step(0, 0, 0, 1, 10, 0, 0, 0, 0, 0);
        step(1, 7, 32'h77, 0, 0, 1, 10, 32'hD0, 0, 0);
        step(0, 0, 0, 1, 10, 0, 0, 0, 10, 0);
        idle(10);
        step(0, 0, 0, 0, 0, 1, 10, 32'hD1, 10, 0);
        idle(10);
        idle(10);
        // Asynchronous reset with two queued results and $9 busy.
        step(1, 1, 32'h11, 1, 9, 1, 14, 32'hE0, 0, 0);
        step(1, 2, 32'h22, 0, 0, 1, 15, 32'hE1, 9, 0);
        wb_RegWrite = 1'b1; wb_WriteReg = 5'd5; wb_WriteData = 32'h99;
        ReadReg1 = 5'd9;
        reset = 1'b1;
        #2;
        chk("midreset_rf_RegWrite", {31'd0, rf_RegWrite}, 32'd0);
        chk("midreset_ready", {31'd0, lu_done_ready}, 32'd0);
        chk("midreset_stall", {31'd0, stall}, 32'd0);
        m_q.delete();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_starve = 0;
        @(posedge Clk); #1;
        reset = 1'b0;
        idle(9);
        idle(14);

        // Random traffic over a small register range to provoke hazards.
        for (int n = 0; n < 2000; n++) begin
            step($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int n = 0; n < 4; n++) idle(0);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
